// File: rtl/iru_pkg.sv
// Shared types and constants for the image rotation unit coordinate path.
// Sine samples are 9-bit sign-magnitude with 0x80 representing 1.0.
package iru_pkg;

    localparam int IRU_DIM         = 20;
    localparam int IRU_LUT_ENTRIES = 36;
    localparam int IRU_QUARTER     = 9;
    localparam int IRU_FRAC_BITS   = 7;
    localparam int IRU_COORD_W     = 7;
    localparam int IRU_SUM_W       = 14;

    typedef struct packed {
        logic       sign;
        logic [7:0] mag;
    } iru_sine_t;

    typedef logic signed [IRU_COORD_W-1:0] iru_coord_t;

    typedef enum logic [1:0] {
        IRU_IDLE  = 2'd0,
        IRU_LOAD  = 2'd1,
        IRU_RUN   = 2'd2,
        IRU_DRAIN = 2'd3
    } iru_state_e;

    // Signed offset times a sign-magnitude sample: unsigned magnitude product, then negate.
    function automatic logic signed [IRU_SUM_W-1:0] iru_sm_mul(input logic signed [5:0] k,
                                                               input iru_sine_t         s);
        logic signed [IRU_SUM_W-1:0] p;
        p = 14'(k) * $signed({6'b0, s.mag});
        return s.sign ? -p : p;
    endfunction

endpackage

// File: rtl/iru_sin_lut.sv
// 36-entry sine table in 10 degree steps, built from one quarter wave.
// Addresses 36 and above read as zero.
module iru_sin_lut
    import iru_pkg::*;
(
    input  logic [5:0] addr_i,
    output iru_sine_t  data_o
);

    function automatic logic [7:0] quarter_mag(input logic [4:0] idx);
        case (idx)
            5'd0:    return 8'd0;
            5'd1:    return 8'd22;
            5'd2:    return 8'd44;
            5'd3:    return 8'd64;
            5'd4:    return 8'd82;
            5'd5:    return 8'd98;
            5'd6:    return 8'd111;
            5'd7:    return 8'd120;
            5'd8:    return 8'd126;
            default: return 8'd128;
        endcase
    endfunction

    logic [4:0] fold;

    always_comb begin
        data_o = '0;
        fold   = (addr_i < 6'd18) ? 5'(addr_i) : 5'(addr_i - 6'd18);
        if (fold > 5'(IRU_QUARTER)) begin
            fold = 5'd18 - fold;
        end
        if (addr_i < 6'(IRU_LUT_ENTRIES)) begin
            data_o.mag  = quarter_mag(fold);
            data_o.sign = (addr_i > 6'd18);
        end
    end

endmodule

// File: rtl/iru_coord_gen.sv
// Rotation coordinate generator: streams one source coordinate per destination pixel.
// Define IRU_COORD_CLAMP_EN to clamp src_x/src_y into the window.
module iru_coord_gen
    import iru_pkg::*;
#(
    parameter int DIM     = IRU_DIM,
    parameter int COORD_W = IRU_COORD_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_valid,
    output logic                      start_ready,
    input  logic [5:0]                angle,
    output logic                      coord_valid,
    input  logic                      coord_ready,
    output logic signed [COORD_W-1:0] src_x,
    output logic signed [COORD_W-1:0] src_y,
    output logic [8:0]                dst_idx,
    output logic                      in_bounds,
    output logic                      last,
    output logic                      busy,
    output logic                      err_angle,
    output logic [1:0]                dbg_state
);

    // Handshakes: a beat or a start transfers on the rising edge where valid && ready;
    // once coord_valid is raised the beat holds stable until coord_ready is seen.

    localparam logic signed [IRU_SUM_W-1:0] CENTER_S = 14'(DIM / 2);
    localparam logic signed [IRU_SUM_W-1:0] DIM_S    = 14'(DIM);
    localparam logic signed [IRU_SUM_W-1:0] ROUND_S  = 14'sd64;

    iru_state_e state_q, state_d;
    logic       err_q, err_d;
    logic [5:0] angle_q;
    logic [5:0] cos_addr;
    iru_sine_t  lut_sin, lut_cos, sin_q, cos_q, sin_use, cos_use;

    logic [4:0] x_q, y_q;
    logic [8:0] idx_q;
    logic       issue, advance, issue_last;
    logic signed [5:0] u, v;

    logic                        p1_valid_q, p1_last_q;
    logic [8:0]                  p1_idx_q;
    logic signed [IRU_SUM_W-1:0] p1_ucos_q, p1_vsin_q, p1_usin_q, p1_vcos_q;

    logic signed [IRU_SUM_W-1:0] sum_x, sum_y, sx_full, sy_full, sx_out, sy_out;
    logic                        inb;

    logic                      coord_valid_q, last_q, in_bounds_q;
    logic signed [COORD_W-1:0] src_x_q, src_y_q;
    logic [8:0]                dst_idx_q;

    assign cos_addr = (angle_q >= 6'd27) ? angle_q - 6'd27 : angle_q + 6'(IRU_QUARTER);

    iru_sin_lut u_sin_lut (.addr_i(angle_q),  .data_o(lut_sin));
    iru_sin_lut u_cos_lut (.addr_i(cos_addr), .data_o(lut_cos));

    // LOAD already issues pixel (0,0) from the live table outputs so the first
    // beat lands two cycles after LOAD, while sin_q/cos_q serve the rest of the window.
    assign sin_use    = (state_q == IRU_LOAD) ? lut_sin : sin_q;
    assign cos_use    = (state_q == IRU_LOAD) ? lut_cos : cos_q;
    assign issue      = (state_q == IRU_LOAD) || (state_q == IRU_RUN);
    assign advance    = !(coord_valid_q && !coord_ready);
    assign issue_last = (x_q == 5'(DIM - 1)) && (y_q == 5'(DIM - 1));
    assign u          = 6'(x_q) - 6'(DIM / 2);
    assign v          = 6'(y_q) - 6'(DIM / 2);

    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        case (state_q)
            IRU_IDLE: begin
                if (start_valid) begin
                    if (angle >= 6'(IRU_LUT_ENTRIES)) err_d   = 1'b1;
                    else                               state_d = IRU_LOAD;
                end
            end
            IRU_LOAD:  state_d = IRU_RUN;
            IRU_RUN:   if (advance && issue_last) state_d = IRU_DRAIN;
            IRU_DRAIN: if (coord_valid_q && coord_ready && last_q) state_d = IRU_IDLE;
            default:   state_d = IRU_IDLE;
        endcase
    end

    function automatic logic signed [IRU_SUM_W-1:0] clamp_coord(input logic signed [IRU_SUM_W-1:0] c);
        if (c < 14'sd0)   return 14'sd0;
        if (c >= DIM_S)   return DIM_S - 14'sd1;
        return c;
    endfunction

    always_comb begin
        sum_x   = p1_ucos_q + p1_vsin_q + ROUND_S;
        sum_y   = p1_vcos_q - p1_usin_q + ROUND_S;
        sx_full = (sum_x >>> IRU_FRAC_BITS) + CENTER_S;
        sy_full = (sum_y >>> IRU_FRAC_BITS) + CENTER_S;
        inb     = (sx_full >= 14'sd0) && (sx_full < DIM_S) &&
                  (sy_full >= 14'sd0) && (sy_full < DIM_S);
`ifdef IRU_COORD_CLAMP_EN
        sx_out  = clamp_coord(sx_full);
        sy_out  = clamp_coord(sy_full);
`else
        sx_out  = sx_full;
        sy_out  = sy_full;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IRU_IDLE;
            err_q         <= 1'b0;
            angle_q       <= '0;
            sin_q         <= '0;
            cos_q         <= '0;
            x_q           <= '0;
            y_q           <= '0;
            idx_q         <= '0;
            p1_valid_q    <= 1'b0;
            p1_last_q     <= 1'b0;
            p1_idx_q      <= '0;
            p1_ucos_q     <= '0;
            p1_vsin_q     <= '0;
            p1_usin_q     <= '0;
            p1_vcos_q     <= '0;
            coord_valid_q <= 1'b0;
            last_q        <= 1'b0;
            in_bounds_q   <= 1'b0;
            src_x_q       <= '0;
            src_y_q       <= '0;
            dst_idx_q     <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (state_q == IRU_IDLE && start_valid) begin
                angle_q <= angle;
            end
            if (state_q == IRU_LOAD) begin
                sin_q <= lut_sin;
                cos_q <= lut_cos;
            end
            if (advance) begin
                p1_valid_q <= issue;
                if (issue) begin
                    p1_ucos_q <= iru_sm_mul(u, cos_use);
                    p1_vsin_q <= iru_sm_mul(v, sin_use);
                    p1_usin_q <= iru_sm_mul(u, sin_use);
                    p1_vcos_q <= iru_sm_mul(v, cos_use);
                    p1_idx_q  <= idx_q;
                    p1_last_q <= issue_last;
                    if (x_q == 5'(DIM - 1)) begin
                        x_q <= '0;
                        y_q <= (y_q == 5'(DIM - 1)) ? 5'd0 : y_q + 5'd1;
                    end else begin
                        x_q <= x_q + 5'd1;
                    end
                    idx_q <= issue_last ? 9'd0 : idx_q + 9'd1;
                end
                coord_valid_q <= p1_valid_q;
                if (p1_valid_q) begin
                    src_x_q     <= COORD_W'(sx_out);
                    src_y_q     <= COORD_W'(sy_out);
                    dst_idx_q   <= p1_idx_q;
                    in_bounds_q <= inb;
                    last_q      <= p1_last_q;
                end
            end
        end
    end

    assign start_ready = (state_q == IRU_IDLE);
    assign busy        = (state_q != IRU_IDLE);
    assign err_angle   = err_q;
    assign dbg_state   = state_q;
    assign coord_valid = coord_valid_q;
    assign src_x       = src_x_q;
    assign src_y       = src_y_q;
    assign dst_idx     = dst_idx_q;
    assign in_bounds   = in_bounds_q;
    assign last        = last_q;

endmodule

// File: tb/tb_iru_coord_gen.sv
// Self-checking bench for iru_coord_gen: trigonometric reference model, scoreboard,
// directed timing/backpressure/reset/error cases and randomized windows.
module tb_iru_coord_gen;

  localparam int DIM = 20;
  localparam int NPIX = DIM * DIM;
  localparam real PI = 3.14159265358979;

  logic clk = 1'b0;
  logic rst;
  logic start_valid;
  logic start_ready;
  logic [5:0] angle;
  logic coord_valid;
  logic coord_ready;
  logic signed [6:0] src_x;
  logic signed [6:0] src_y;
  logic [8:0] dst_idx;
  logic in_bounds;
  logic last;
  logic busy;
  logic err_angle;
  logic [1:0] dbg_state;

  iru_coord_gen dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready), .angle(angle),
    .coord_valid(coord_valid), .coord_ready(coord_ready),
    .src_x(src_x), .src_y(src_y), .dst_idx(dst_idx),
    .in_bounds(in_bounds), .last(last), .busy(busy),
    .err_angle(err_angle), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int sm_val(input int deg);
    real r;
    int m;
    r = $sin(deg * PI / 180.0);
    m = $rtoi(((r < 0.0) ? -r : r) * 128.0 + 0.5);
    return (r < 0.0) ? -m : m;
  endfunction

  function automatic int clamp_win(input int c);
    if (c < 0) return 0;
    if (c > DIM - 1) return DIM - 1;
    return c;
  endfunction

  // {src_x[6:0], src_y[6:0], dst_idx[8:0], in_bounds, last}
  function automatic logic [24:0] model_beat(input int a, input int idx);
    int s, c, x, y, u, v, sx, sy, ox, oy;
    logic inb;
    logic [6:0] px, py;
    logic [8:0] pi9;
    s = sm_val(a * 10);
    c = sm_val(a * 10 + 90);
    x = idx % DIM;
    y = idx / DIM;
    u = x - DIM / 2;
    v = y - DIM / 2;
    sx = ((u * c + v * s + 64) >>> 7) + DIM / 2;
    sy = ((v * c - u * s + 64) >>> 7) + DIM / 2;
    inb = (sx >= 0) && (sx < DIM) && (sy >= 0) && (sy < DIM);
`ifdef IRU_COORD_CLAMP_EN
    ox = clamp_win(sx);
    oy = clamp_win(sy);
`else
    ox = sx;
    oy = sy;
`endif
    px = 7'(ox);
    py = 7'(oy);
    pi9 = 9'(idx);
    return {px, py, pi9, inb, (idx == NPIX - 1)};
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [24:0] exp_q[$];
  bit mon_en = 1'b0;
  bit prev_stall = 1'b0;
  int beat_cnt = 0;
  int last_cnt = 0;
  int first_cyc = 0;
  int last_cyc = 0;
  int first_x, first_y, first_inb, last_x, last_y;

  always @(negedge clk) begin
    logic [24:0] e;
    if (mon_en) begin
      if (prev_stall) check("valid_held", coord_valid, 1);
      if (coord_valid) begin
        if (exp_q.size() == 0) begin
          check("extra_beat_valid", coord_valid, 0);
        end else begin
          e = exp_q[0];
          check("src_x", src_x, $signed(e[24:18]));
          check("src_y", src_y, $signed(e[17:11]));
          check("dst_idx", dst_idx, e[10:2]);
          check("in_bounds", in_bounds, e[1]);
          check("last", last, e[0]);
          if (coord_ready) begin
            void'(exp_q.pop_front());
            beat_cnt++;
            if (dst_idx == 9'd0) begin
              first_cyc = cyc;
              first_x = src_x;
              first_y = src_y;
              first_inb = in_bounds;
            end
            if (last) begin
              last_cnt++;
              last_cyc = cyc;
              last_x = src_x;
              last_y = src_y;
            end
          end
        end
      end
      prev_stall = coord_valid && !coord_ready;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- drivers ----------------
  int ready_mode = 0;  // 0: high, 1: random, 2: low

  initial begin
    coord_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (ready_mode == 0) coord_ready = 1'b1;
      else if (ready_mode == 2) coord_ready = 1'b0;
      else coord_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic start_req(input logic [5:0] a, output int t_hs);
    t_hs = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (start_ready) break;
    end
    if (!start_ready) check("start_ready_wait", start_ready, 1);
    start_valid = 1'b1;
    angle = a;
    t_hs = cyc;
  endtask

  task automatic run_window(input int a, input bit chk_t, input bit bp, input bit poke);
    int t_hs, b0, l0, n;
    for (int i = 0; i < NPIX; i++) exp_q.push_back(model_beat(a, i));
    b0 = beat_cnt;
    l0 = last_cnt;
    start_req(6'(a), t_hs);
    n = 0;
    forever begin
      @(posedge clk);
      #1;
      start_valid = poke && (cyc == t_hs + 50);
      if (start_valid) angle = 6'd3;
      if (bp && cyc == t_hs + 40) ready_mode = 2;
      if (bp && cyc == t_hs + 45) ready_mode = 0;
      if (bp && (cyc == t_hs + 40 || cyc == t_hs + 44)) begin
        @(negedge clk);
        check("bp_valid", coord_valid, 1);
        check("bp_dst", dst_idx, 37);
        check("bp_x", src_x, 17);
        check("bp_y", src_y, 1);
      end
      if (beat_cnt - b0 >= NPIX) break;
      n++;
      if (n > 4000) begin
        check("window_timeout", beat_cnt - b0, NPIX);
        break;
      end
    end
    start_valid = 1'b0;
    @(negedge clk);
    check("start_ready_after", start_ready, 1);
    check("busy_after", busy, 0);
    check("beats", beat_cnt - b0, NPIX);
    check("last_count", last_cnt - l0, 1);
    if (chk_t) begin
      check("first_latency", first_cyc - t_hs, 3);
      check("last_latency", last_cyc - t_hs, 2 + NPIX);
    end
    repeat (10) @(negedge clk);
    check("no_extra_beats", beat_cnt - b0, NPIX);
    check("queue_empty", exp_q.size(), 0);
  endtask

  task automatic bad_angle(input logic [5:0] a);
    int t_hs, b0;
    b0 = beat_cnt;
    start_req(a, t_hs);
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    @(negedge clk);
    check("err_pulse", err_angle, 1);
    check("err_start_ready", start_ready, 1);
    check("err_no_valid", coord_valid, 0);
    check("err_busy", busy, 0);
    @(negedge clk);
    check("err_one_cycle", err_angle, 0);
    repeat (5) @(negedge clk);
    check("err_no_beats", beat_cnt - b0, 0);
  endtask

  task automatic check_idle_zero(input string pfx);
    check({pfx, "_valid"}, coord_valid, 0);
    check({pfx, "_last"}, last, 0);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_err"}, err_angle, 0);
    check({pfx, "_src_x"}, src_x, 0);
    check({pfx, "_src_y"}, src_y, 0);
    check({pfx, "_dst"}, dst_idx, 0);
    check({pfx, "_inb"}, in_bounds, 0);
    check({pfx, "_ready"}, start_ready, 1);
    check({pfx, "_state"}, dbg_state, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t_hs, n;
    rst = 1'b1;
    start_valid = 1'b0;
    angle = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_zero("reset");
    mon_en = 1'b1;

    // angle 0, ready high, with a start poke during RUN
    run_window(0, 1'b1, 1'b0, 1'b1);
    check("a0_first_x", first_x, 0);
    check("a0_first_y", first_y, 0);
    check("a0_first_inb", first_inb, 1);
    check("a0_last_x", last_x, 19);
    check("a0_last_y", last_y, 19);

    // 90 degrees
    run_window(9, 1'b1, 1'b0, 1'b0);
    check("a9_first_x", first_x, 0);
`ifdef IRU_COORD_CLAMP_EN
    check("a9_first_y", first_y, 19);
`else
    check("a9_first_y", first_y, 20);
`endif
    check("a9_first_inb", first_inb, 0);

    // backpressure at dst 37
    run_window(0, 1'b0, 1'b1, 1'b0);

    bad_angle(6'd40);

    // reset mid-window at dst 100
    for (int i = 0; i < NPIX; i++) exp_q.push_back(model_beat(0, i));
    start_req(6'd0, t_hs);
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    n = 0;
    forever begin
      @(negedge clk);
      if (coord_valid && dst_idx == 9'd100) break;
      n++;
      if (n > 1000) begin
        check("reach_dst100", dst_idx, 100);
        break;
      end
    end
    rst = 1'b1;
    mon_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_idle_zero("midreset");
    mon_en = 1'b1;
    run_window(0, 1'b1, 1'b0, 1'b0);
    check("restart_first_x", first_x, 0);

    // randomized windows under random backpressure
    for (int k = 0; k < 4; k++) begin
      ready_mode = 1;
      run_window($urandom_range(0, 35), 1'b0, 1'b0, ($urandom_range(0, 1) == 1));
      ready_mode = 0;
    end
    bad_angle(6'($urandom_range(36, 63)));
    run_window($urandom_range(0, 35), 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
